// File: rtl/bcd_stopwatch_ctrl_if.sv
// Command and display bundle between user logic and the BCD stopwatch controller.
// The master side issues level commands and the slave side returns the BCD status.
interface bcd_stopwatch_ctrl_if;
  logic        start;
  logic        stop;
  logic        clear;
  logic        lap;
  logic [15:0] count;
  logic [15:0] lap_count;
  logic        running;
  logic        tick;
  logic        ovf;

  modport master (
    output start, stop, clear, lap,
    input  count, lap_count, running, tick, ovf
  );

  modport slave (
    input  start, stop, clear, lap,
    output count, lap_count, running, tick, ovf
  );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// Start/stop/clear stopwatch: a prescaler gated by an IDLE/RUN/PAUSE FSM drives
// a 4-digit BCD ripple counter, with a lap snapshot register and sticky overflow.
module bcd_stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic                clk,
  input  logic                rst,
  bcd_stopwatch_ctrl_if.slave sw
);

  localparam int unsigned PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DIGITS  = 4;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   lap_q, lap_d;
  logic          ovf_q, ovf_d;
  logic          tick_q;
  logic          running_q;
  logic          inc;
  logic          carry;

  // Command decode, prescaler advance and BCD ripple increment.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    count_d = count_q;
    lap_d   = lap_q;
    ovf_d   = ovf_q;
    inc     = 1'b0;
    carry   = 1'b0;

    if (sw.clear) begin
      state_d = IDLE;
      pre_d   = '0;
      count_d = '0;
      lap_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      if (sw.lap) begin
        lap_d = count_q;
      end

      unique case (state_q)
        IDLE: begin
          if (sw.start) begin
            state_d = RUN;
            pre_d   = '0;
          end
        end
        RUN: begin
          if (sw.stop) begin
            state_d = PAUSE;
          end else if (pre_q == PRE_MAX) begin
            pre_d = '0;
            inc   = 1'b1;
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        PAUSE: begin
          if (sw.start && !sw.stop) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase

      // Carry survives past the last digit only on the 9999 -> 0000 wrap.
      carry = inc;
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (count_q[i*4 +: 4] == 4'd9) begin
            count_d[i*4 +: 4] = 4'd0;
          end else begin
            count_d[i*4 +: 4] = count_q[i*4 +: 4] + 4'd1;
            carry             = 1'b0;
          end
        end
      end
      if (carry) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      count_q   <= '0;
      lap_q     <= '0;
      ovf_q     <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      count_q   <= count_d;
      lap_q     <= lap_d;
      ovf_q     <= ovf_d;
      tick_q    <= inc;
      running_q <= (state_d == RUN);
    end
  end

  assign sw.count     = count_q;
  assign sw.lap_count = lap_q;
  assign sw.running   = running_q;
  assign sw.tick      = tick_q;
  assign sw.ovf       = ovf_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: two instances (TICK_DIV=4 and TICK_DIV=1) checked
// every cycle against an integer-valued stopwatch model plus directed scenarios.
module tb_bcd_stopwatch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, rst1;
  bcd_stopwatch_ctrl_if if4();
  bcd_stopwatch_ctrl_if if1();

  bcd_stopwatch_ctrl #(.TICK_DIV(4)) dut4 (.clk(clk), .rst(rst4), .sw(if4.slave));
  bcd_stopwatch_ctrl #(.TICK_DIV(1)) dut1 (.clk(clk), .rst(rst1), .sw(if1.slave));

  int total = 0;
  int bad   = 0;

  // Stimulus per instance (index 0: TICK_DIV=4, index 1: TICK_DIV=1).
  bit in_rst[2], in_start[2], in_stop[2], in_clear[2], in_lap[2];

  // Model: decimal count value, prescaler, lap value, mode 0=idle 1=run 2=pause.
  int m_val[2], m_pre[2], m_lap[2], m_st[2];
  bit m_tick[2], m_ovf[2];

  function automatic int div_of(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic [15:0] bcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [34:0] expv(int d);
    return {bcd(m_val[d]), bcd(m_lap[d]), (m_st[d] == 1), m_tick[d], m_ovf[d]};
  endfunction

  function automatic logic [34:0] obs(int d);
    if (d == 0) return {if4.count, if4.lap_count, if4.running, if4.tick, if4.ovf};
    return {if1.count, if1.lap_count, if1.running, if1.tick, if1.ovf};
  endfunction

  task automatic model_edge(int d);
    bit inc;
    inc = 1'b0;
    if (!in_rst[d] || in_clear[d]) begin
      m_st[d] = 0; m_val[d] = 0; m_pre[d] = 0; m_lap[d] = 0; m_ovf[d] = 1'b0;
    end else begin
      if (in_lap[d]) m_lap[d] = m_val[d];
      if (m_st[d] == 0) begin
        if (in_start[d]) begin m_st[d] = 1; m_pre[d] = 0; end
      end else if (m_st[d] == 1) begin
        if (in_stop[d]) m_st[d] = 2;
        else begin
          m_pre[d] = m_pre[d] + 1;
          if (m_pre[d] == div_of(d)) begin m_pre[d] = 0; inc = 1'b1; end
        end
      end else if (in_start[d] && !in_stop[d]) begin
        m_st[d] = 1;
      end
      if (inc) begin
        m_val[d] = m_val[d] + 1;
        if (m_val[d] == 10000) begin m_val[d] = 0; m_ovf[d] = 1'b1; end
      end
    end
    m_tick[d] = inc;
  endtask

  // Apply current stimulus, take one rising edge, advance both models, settle.
  task automatic edge_step();
    rst4 = in_rst[0]; if4.start = in_start[0]; if4.stop = in_stop[0];
    if4.clear = in_clear[0]; if4.lap = in_lap[0];
    rst1 = in_rst[1]; if1.start = in_start[1]; if1.stop = in_stop[1];
    if1.clear = in_clear[1]; if1.lap = in_lap[1];
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic clear_cmds(int d);
    in_start[d] = 0; in_stop[d] = 0; in_clear[d] = 0; in_lap[d] = 0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin in_rst[d] = 0; clear_cmds(d); end
    edge_step();
    edge_step();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs(d) !== 35'd0) begin
        bad++; $display("FAIL reset d=%0d got=%h want=0", d, obs(d));
      end
      total++;
      if (obs(d) !== expv(d)) begin
        bad++; $display("FAIL reset_model d=%0d got=%h want=%h", d, obs(d), expv(d));
      end
    end
    in_rst[0] = 1; in_rst[1] = 1;
  endtask

  task automatic test_first_ticks(string tag);
    in_start[0] = 1;
    edge_step();
    in_start[0] = 0;
    total++;
    if (if4.running !== 1'b1) begin
      bad++; $display("FAIL %s_running got=%b want=1", tag, if4.running);
    end
    for (int e = 1; e <= 10; e++) begin
      edge_step();
      total++;
      if (if4.tick !== ((e == 4) || (e == 8))) begin
        bad++; $display("FAIL %s_tick edge=%0d got=%b", tag, e, if4.tick);
      end
      total++;
      if (if4.count !== ((e >= 8) ? 16'h0002 : (e >= 4) ? 16'h0001 : 16'h0000)) begin
        bad++; $display("FAIL %s_count edge=%0d got=%h", tag, e, if4.count);
      end
      total++;
      if (obs(0) !== expv(0)) begin
        bad++; $display("FAIL %s_model edge=%0d got=%h want=%h", tag, e, obs(0), expv(0));
      end
    end
  endtask

  task automatic test_carry();
    in_start[1] = 1;
    edge_step();
    in_start[1] = 0;
    for (int i = 1; i <= 1000; i++) begin
      edge_step();
      total++;
      if (obs(1) !== expv(1)) begin
        bad++; $display("FAIL carry i=%0d got=%h want=%h", i, obs(1), expv(1));
      end
      if (i == 10 || i == 100 || i == 1000) begin
        total++;
        if (if1.count !== ((i == 10) ? 16'h0010 : (i == 100) ? 16'h0100 : 16'h1000)) begin
          bad++; $display("FAIL carry_edge i=%0d got=%h", i, if1.count);
        end
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 1001; i <= 10000; i++) begin
      edge_step();
      total++;
      if (obs(1) !== expv(1)) begin
        bad++; $display("FAIL wrap i=%0d got=%h want=%h", i, obs(1), expv(1));
      end
    end
    total++;
    if ({if1.count, if1.ovf, if1.running} !== {16'h0000, 1'b1, 1'b1}) begin
      bad++; $display("FAIL wrap_ovf got count=%h ovf=%b run=%b", if1.count, if1.ovf, if1.running);
    end
    edge_step();
    total++;
    if ({if1.count, if1.ovf} !== {16'h0001, 1'b1}) begin
      bad++; $display("FAIL wrap_after got count=%h ovf=%b", if1.count, if1.ovf);
    end
    in_clear[1] = 1;
    edge_step();
    in_clear[1] = 0;
    total++;
    if ({if1.count, if1.ovf, if1.running, if1.tick} !== 19'd0) begin
      bad++; $display("FAIL wrap_clear got count=%h ovf=%b run=%b", if1.count, if1.ovf, if1.running);
    end
    edge_step();
    total++;
    if (obs(1) !== 35'd0) begin
      bad++; $display("FAIL wrap_idle got=%h want=0", obs(1));
    end
  endtask

  task automatic test_pause_resume();
    bit found;
    in_clear[0] = 1; edge_step(); in_clear[0] = 0;
    in_start[0] = 1; edge_step(); in_start[0] = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_val[0] == 5 && m_pre[0] == 3) found = 1;
      else begin
        edge_step();
        total++;
        if (obs(0) !== expv(0)) begin
          bad++; $display("FAIL pause_run got=%h want=%h", obs(0), expv(0));
        end
      end
    end
    total++;
    if (!found) begin bad++; $display("FAIL pause_reach timeout got=%0d want=5", m_val[0]); end
    in_stop[0] = 1; edge_step(); in_stop[0] = 0;
    total++;
    if ({if4.count, if4.running, if4.tick} !== {16'h0005, 1'b0, 1'b0}) begin
      bad++; $display("FAIL pause_stop got count=%h run=%b tick=%b", if4.count, if4.running, if4.tick);
    end
    for (int i = 0; i < 20; i++) begin
      edge_step();
      total++;
      if (if4.count !== 16'h0005 || obs(0) !== expv(0)) begin
        bad++; $display("FAIL pause_hold i=%0d got=%h want=0005", i, if4.count);
      end
    end
    in_start[0] = 1; edge_step(); in_start[0] = 0;
    total++;
    if ({if4.count, if4.running} !== {16'h0005, 1'b1}) begin
      bad++; $display("FAIL resume_edge got count=%h run=%b", if4.count, if4.running);
    end
    edge_step();
    total++;
    if ({if4.count, if4.tick} !== {16'h0006, 1'b1}) begin
      bad++; $display("FAIL resume_inc got count=%h tick=%b want 0006/1", if4.count, if4.tick);
    end
  endtask

  task automatic test_priority();
    bit found;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (m_val[0] == 41 && m_pre[0] == 3) found = 1;
      else edge_step();
    end
    total++;
    if (!found) begin bad++; $display("FAIL prio_reach timeout got=%0d want=41", m_val[0]); end
    in_lap[0] = 1; edge_step(); in_lap[0] = 0;
    total++;
    if ({if4.count, if4.lap_count} !== {16'h0042, 16'h0041}) begin
      bad++; $display("FAIL lap_inc got count=%h lap=%h want 0042/0041", if4.count, if4.lap_count);
    end
    in_clear[0] = 1; in_start[0] = 1; in_lap[0] = 1;
    edge_step();
    clear_cmds(0);
    total++;
    if ({if4.count, if4.lap_count, if4.running} !== 33'd0) begin
      bad++; $display("FAIL prio_clear got count=%h lap=%h run=%b", if4.count, if4.lap_count, if4.running);
    end
  endtask

  task automatic test_reset_midrun();
    bit found;
    in_start[0] = 1; edge_step(); in_start[0] = 0;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (m_val[0] == 377) found = 1;
      else edge_step();
    end
    total++;
    if (!found || if4.count !== 16'h0377) begin
      bad++; $display("FAIL midrun_reach got=%h want=0377", if4.count);
    end
    in_lap[0] = 1; edge_step(); in_lap[0] = 0;
    in_rst[0] = 0; edge_step(); in_rst[0] = 1;
    total++;
    if (obs(0) !== 35'd0) begin
      bad++; $display("FAIL midrun_reset got=%h want=0", obs(0));
    end
    test_first_ticks("rerun");
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        in_rst[d]   = ($urandom_range(255) != 0);
        in_start[d] = ($urandom_range(7) == 0);
        in_stop[d]  = ($urandom_range(15) == 0);
        in_clear[d] = ($urandom_range(63) == 0);
        in_lap[d]   = ($urandom_range(7) == 0);
      end
      edge_step();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs(d) !== expv(d)) begin
          bad++; $display("FAIL random i=%0d d=%0d got=%h want=%h", i, d, obs(d), expv(d));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_ticks("basic");
    test_carry();
    test_wrap();
    test_pause_resume();
    test_priority();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
# bcd_stopwatch_ctrl

Controller that sequences a 4-digit cascade of BCD decade counters (each digit counts 0-9, wrapping 9 to 0) as a start/stop/clear stopwatch. A parameterised prescaler turns the system clock into count ticks. A 3-state FSM gates those ticks, and a lap register snapshots the running value. The block sits between user/command logic and display logic, and owns all enable and carry sequencing of the digit counters.

## Interface
- TICK_DIV, default 10: clock cycles per count increment; legal range ≥1. Prescaler width is max(1, clog2(TICK_DIV)).
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  level command: begin or resume counting.
- stop  in  1  level command: pause counting.
- clear  in  1  level command: return to zero and idle.
- lap  in  1  level command: capture the current count into lap_count.
- count  out  16  live value, 4 BCD digits; [15:12] thousands … [3:0] units.
- lap_count  out  16  last captured value, 4 BCD digits.
- running  out  1  high while the FSM is in RUN.
- tick  out  1  one-cycle pulse, high in the cycle following each increment edge.
- ovf  out  1  sticky; set on the 9999→0000 wrap.

## Operation
- Reset (rst=0 at an edge) sets the following: FSM=IDLE, count=0000, lap_count=0000, prescaler=0, tick=0, ovf=0, running=0.
- FSM states are IDLE, RUN and PAUSE. Command priority is clear > stop > start.
  - Any state, clear=1: go to IDLE. count, prescaler and ovf are zeroed. lap_count is zeroed.
  - IDLE, start=1 (no clear): go to RUN with prescaler=0.
  - RUN, stop=1 (no clear): go to PAUSE. count and prescaler hold.
  - PAUSE, start=1 with stop=0 (no clear): go to RUN. The prescaler resumes from its held value.
  - All other combinations hold the current state.
- Prescaler behaviour depends on state:
  - It advances only in RUN on an edge with stop=0 and clear=0.
  - If it equals TICK_DIV-1, it reloads 0 and count increments on that same edge. Otherwise it increments by 1.
- Count increment is a BCD ripple:
  - The units digit increments.
  - A digit at 9 becomes 0 and carries into the next digit.
  - All 4 digits update on the same edge.
  - 9999 becomes 0000 and sets ovf=1 on that edge.
  - No digit ever holds a value above 9.
- Lap: lap=1 at an edge with clear=0 loads lap_count with the pre-edge count. This applies in any state, including on an increment edge, where the pre-increment value is captured. clear overrides lap.
- tick is a registered copy of "increment occurred this edge".
- running is registered and equals (state==RUN).

## Timing
- Start latency: start sampled at edge k gives running=1 after edge k. The first increment occurs at edge k+TICK_DIV. With TICK_DIV=1, increments occur at every edge from k+1.
- Steady-state period: one increment every TICK_DIV cycles. tick is high for exactly 1 cycle per increment.
- Stop latency: stop sampled at edge k gives no increment at edge k, even if the prescaler equals TICK_DIV-1. running=0 after edge k.
- Resume: the first increment after a PAUSE→RUN transition occurs TICK_DIV minus the held prescaler value edges after the resume edge.
- Clear and reset take effect at the sampling edge. All outputs show their reset/clear values from the following cycle. Both are legal mid-RUN and mid-carry.
- Simultaneous start+stop: in RUN the result is PAUSE; in PAUSE the FSM stays in PAUSE; in IDLE the result is RUN, since stop is ignored in IDLE.

## Test plan
- TICK_DIV=4: release rst, pulse start at edge 0 → count=0001 after edge 4 and 0002 after edge 8; tick high the cycle after edges 4 and 8 only.
- Carry chain, TICK_DIV=1: run 9 cycles → 0009, next edge → 0010; at 0099 → 0100; at 0999 → 1000.
- Wrap, TICK_DIV=1: run 10000 increments → count=0000, ovf=1 and remaining 1 while counting continues. clear → ovf=0, count=0000, state IDLE.
- Pause/resume, TICK_DIV=4: stop asserted when prescaler=3 at count 0005 → no increment, count holds 0005 for 20 cycles. start → count=0006 exactly 1 edge later, because the prescaler was held at 3.
- Priority: clear+start+lap in the same cycle at count 0042 → IDLE, count=0000, lap_count=0000. Separately, lap on an increment edge at 0041→0042 → lap_count=0041.
- rst=0 mid-RUN at count 0377 → all outputs at reset values after that edge. A following start behaves exactly like the first scenario.
